// File: rtl/task2_fillscreen_pkg.sv
// Shared screen geometry, counter widths and the fill state encoding for the
// task2 screen filler.
package task2_fillscreen_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // Terminal coordinates; the scan stops on these, never on counter overflow.
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } fill_state_t;

endpackage

// File: rtl/task2_fillscreen_if.sv
// Pixel-write bundle between the fill engine and whoever consumes its plots
// (the board-level VGA pins, or a bench monitor).
interface task2_fillscreen_if;
  import task2_fillscreen_pkg::*;

  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done;

  modport master (output x, y, colour, plot, done);
  modport slave  (input  x, y, colour, plot, done);

endinterface

// File: rtl/task2_fillscreen_fillscreen.sv
// Column-major screen fill engine: plots every pixel of the screen exactly
// once, one per clock, colouring each by its column modulo 8, then stops.
module fillscreen
  import task2_fillscreen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  fill_state_t    r_state;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;

  fill_state_t    w_nextState;
  logic [X_W-1:0] w_nextX;
  logic [Y_W-1:0] w_nextY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_nextState;
      r_x     <= w_nextX;
      r_y     <= w_nextY;
    end
  end

  // The plot strobe is gated by rst so it drops the instant reset asserts,
  // not at the next edge.
  always_comb begin
    w_nextState = r_state;
    w_nextX     = r_x;
    w_nextY     = r_y;
    vga_plot    = 1'b0;
    done        = 1'b0;
    case (r_state)
      FILL: begin
        vga_plot = ~rst;
        if (r_y == Y_LAST) begin
          if (r_x == X_LAST) begin
            w_nextState = DONE;
          end else begin
            w_nextY = '0;
            w_nextX = r_x + X_W'(1);
          end
        end else begin
          w_nextY = r_y + Y_W'(1);
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        w_nextState = FILL;
      end
    endcase
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_x[COLOUR_W-1:0];

endmodule

// File: rtl/task2_fillscreen.sv
// Board-level wrapper: wires the fill engine to the DE-style pins and ties off
// the displays and the VGA nets owned by the external adapter.
module task2_fillscreen
  import task2_fillscreen_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_CLK,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [2:0]  VGA_COLOUR,
  output logic        VGA_PLOT
);

  task2_fillscreen_if w_pix ();

  logic w_unused;
  assign w_unused = &{1'b0, SW, KEY[2:0]};

  fillscreen u_fillscreen (
    .clk        (CLOCK_50),
    .rst        (KEY[3]),
    .done       (w_pix.done),
    .vga_x      (w_pix.x),
    .vga_y      (w_pix.y),
    .vga_colour (w_pix.colour),
    .vga_plot   (w_pix.plot)
  );

  assign VGA_X      = w_pix.x;
  assign VGA_Y      = w_pix.y;
  assign VGA_COLOUR = w_pix.colour;
  assign VGA_PLOT   = w_pix.plot;
  assign LEDR       = {9'b0, w_pix.done};

  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;

  // The VGA adapter drives these nets; this design must stay off them.
  assign VGA_R   = 'z;
  assign VGA_G   = 'z;
  assign VGA_B   = 'z;
  assign VGA_HS  = 1'bz;
  assign VGA_VS  = 1'bz;
  assign VGA_CLK = 1'bz;

endmodule

// File: tb/tb_task2_fillscreen.sv
// Scoreboard bench for task2_fillscreen: a reference model queues every pixel
// a fill must produce, and a negedge monitor pops and compares each cycle.
module tb_task2_fillscreen;
  import task2_fillscreen_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pixel_t;

  logic       clk;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [7:0] vgaR, vgaG, vgaB;
  logic       vgaHs, vgaVs, vgaClk;

  task2_fillscreen_if pix ();

  task2_fillscreen dut (
    .CLOCK_50   (clk),
    .KEY        (KEY),
    .SW         (SW),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .VGA_R      (vgaR),
    .VGA_G      (vgaG),
    .VGA_B      (vgaB),
    .VGA_HS     (vgaHs),
    .VGA_VS     (vgaVs),
    .VGA_CLK    (vgaClk),
    .VGA_X      (pix.x),
    .VGA_Y      (pix.y),
    .VGA_COLOUR (pix.colour),
    .VGA_PLOT   (pix.plot)
  );

  assign pix.done = LEDR[0];

  pixel_t expQ[$];
  bit     fillActive = 1'b0;
  int     vectors = 0;
  int     miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 25)
        $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every pixel of the screen, column by column, colour = column mod 8.
  task automatic loadModel();
    expQ.delete();
    for (int col = 0; col < SCREEN_W; col++)
      for (int row = 0; row < SCREEN_H; row++)
        expQ.push_back('{x: 8'(col), y: 7'(row), c: 3'(col % 8)});
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      SW       = 10'($urandom);
      KEY[2:0] = 3'($urandom);
    end
  endtask

  task automatic pulseReset(input int len);
    @(posedge clk);
    #1;
    KEY[3]     = 1'b1;
    fillActive = 1'b0;
    expQ.delete();
    repeat (len) @(posedge clk);
    #1;
    KEY[3] = 1'b0;
    loadModel();
    fillActive = 1'b1;
  endtask

  task automatic waitFill(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 19210) begin
      @(posedge clk);
      n++;
    end
    checkOutput({name, "_fill_timeout"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: reset outputs while KEY[3] is high, scoreboard pops while
  // filling, and a held DONE picture once the model is exhausted.
  always @(negedge clk) begin
    automatic pixel_t e;
    if (KEY[3] === 1'b1) begin
      checkOutput("reset_outputs", {3'b0, pix.plot, pix.x, pix.y, pix.colour, LEDR},
                  32'd0);
    end else if (fillActive) begin
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("plot_pixel", {3'b0, pix.plot, pix.x, pix.y, pix.colour, LEDR},
                    {3'b0, 1'b1, e.x, e.y, e.c, 10'd0});
        checkOutput("range", {30'b0, pix.x < 8'd160, pix.y < 7'd120}, 32'd3);
      end else begin
        checkOutput("done_hold", {3'b0, pix.plot, pix.x, pix.y, pix.colour, LEDR},
                    {3'b0, 1'b0, 8'd159, 7'd119, 3'd7, 10'd1});
      end
    end
    checkOutput("hex0_3", {4'b0, HEX0, HEX1, HEX2, HEX3}, {4'b0, {4{7'h7F}}});
    checkOutput("hex4_5", {18'b0, HEX4, HEX5}, {18'b0, {2{7'h7F}}});
  end

  initial begin
    int midCycle;
    KEY = 4'b0000;
    SW  = 10'd0;
    #1;
    KEY[3] = 1'b1;
    $display("[TB] single-cycle reset pulse, full fill");
    pulseReset(1);
    waitFill("first");
    applyStimulus(12);

    $display("[TB] reset aborts a fill in progress");
    pulseReset(1);
    midCycle = $urandom_range(4900, 5100);
    applyStimulus(midCycle);
    pulseReset($urandom_range(1, 3));
    waitFill("restart");
    applyStimulus(12);

    $display("[TB] reset from DONE starts a fresh fill");
    pulseReset($urandom_range(1, 4));
    waitFill("from_done");
    applyStimulus(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
